// File: rtl/azadi_board_gpio_pkg.sv
// ============================================================================
//  Module      : azadi_board_gpio_pkg
//  Description : Shared defaults and helpers for the board-level GPIO bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package azadi_board_gpio_pkg;

    // Default build of the bridge: four pins taken from SoC GPIO bits 19:16.
    localparam int c_NUM_PINS_DEF        = 4;
    localparam int c_SOC_GPIO_W_DEF      = 20;
    localparam int c_PIN_OFFSET_DEF      = 16;
    localparam int c_SYNC_STAGES_DEF     = 2;
    localparam int c_DEBOUNCE_CYCLES_DEF = 4;

    // Debounce counter width; a bypassed filter still gets a 1-bit width so
    // the expression stays legal even though no counter is built.
    function automatic int deb_cnt_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage : azadi_board_gpio_pkg

`default_nettype wire

// File: rtl/azadi_board_gpio_if.sv
// ============================================================================
//  Module      : azadi_board_gpio_if
//  Description : SoC-side GPIO bus and event-control bundle of the bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface azadi_board_gpio_if
    import azadi_board_gpio_pkg::*;
#(
    parameter int NUM_PINS   = c_NUM_PINS_DEF,
    parameter int SOC_GPIO_W = c_SOC_GPIO_W_DEF
);
    logic [SOC_GPIO_W-1:0] soc_gpio_o;
    logic [SOC_GPIO_W-1:0] soc_gpio_oe;
    logic [SOC_GPIO_W-1:0] soc_gpio_i;
    logic [NUM_PINS-1:0]   evt_rise_en_i;
    logic [NUM_PINS-1:0]   evt_fall_en_i;
    logic [NUM_PINS-1:0]   evt_clear_i;
    logic [NUM_PINS-1:0]   evt_status_o;
    logic                  irq_o;

    // SoC side drives the GPIO vectors and event controls.
    modport master (
        output soc_gpio_o, soc_gpio_oe, evt_rise_en_i, evt_fall_en_i, evt_clear_i,
        input  soc_gpio_i, evt_status_o, irq_o
    );

    // Bridge side returns debounced inputs, status and interrupt.
    modport slave (
        input  soc_gpio_o, soc_gpio_oe, evt_rise_en_i, evt_fall_en_i, evt_clear_i,
        output soc_gpio_i, evt_status_o, irq_o
    );

endinterface : azadi_board_gpio_if

`default_nettype wire

// File: rtl/azadi_gpio_debounce.sv
// ============================================================================
//  Module      : azadi_gpio_debounce
//  Description : Single-pin synchroniser, debounce filter and edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module azadi_gpio_debounce
    import azadi_board_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = c_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
    input  wire logic clock,
    input  wire logic reset_ni,
    input  wire logic i_pin,
    output logic      o_deb,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_deb;
    logic                   r_deb_prev;

    // Metastability chain: the asynchronous pin enters at bit 0.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the debounced value is just the synced value, one flop later.
            always_ff @(posedge clock) begin
                if (!reset_ni) begin
                    r_deb <= 1'b0;
                end else begin
                    r_deb <= w_sync;
                end
            end
        end else begin : g_filter
            localparam int               CNT_W      = deb_cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;

            // Count consecutive differing samples; flip only after a full run.
            always_ff @(posedge clock) begin
                if (!reset_ni) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (w_sync == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt <= '0;
                    r_deb <= w_sync;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Previous debounced value; both reset low so reset release makes no edge.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_deb_prev <= 1'b0;
        end else begin
            r_deb_prev <= r_deb;
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_deb & ~r_deb_prev;
    assign o_fall = ~r_deb & r_deb_prev;

endmodule : azadi_gpio_debounce

`default_nettype wire

// File: rtl/azadi_board_gpio.sv
// ============================================================================
//  Module      : azadi_board_gpio
//  Description : Board GPIO bridge - maps a SoC GPIO slice onto board pins
//                with debounced inputs, sticky edge events and registered
//                outputs with per-pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module azadi_board_gpio
    import azadi_board_gpio_pkg::*;
#(
    parameter int                  NUM_PINS        = c_NUM_PINS_DEF,
    parameter int                  SOC_GPIO_W      = c_SOC_GPIO_W_DEF,
    parameter int                  PIN_OFFSET      = c_PIN_OFFSET_DEF,
    parameter int                  SYNC_STAGES     = c_SYNC_STAGES_DEF,
    parameter int                  DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter logic [NUM_PINS-1:0] OUT_INVERT      = '0
) (
    input  wire logic                clock,
    input  wire logic                reset_ni,
    input  wire logic [NUM_PINS-1:0] pin_i,
    output logic      [NUM_PINS-1:0] pin_o,
    output logic      [NUM_PINS-1:0] pin_oe_o,
    azadi_board_gpio_if.slave        bus
);

    // Refuse to build with a slice that falls outside the SoC bus.
    generate
        if (NUM_PINS < 1 || NUM_PINS > 32 || PIN_OFFSET < 0 ||
            PIN_OFFSET + NUM_PINS > SOC_GPIO_W || SYNC_STAGES < 2 ||
            DEBOUNCE_CYCLES < 0) begin : g_param_check
            $fatal(1, "azadi_board_gpio: illegal PIN_OFFSET/NUM_PINS/SYNC_STAGES");
        end
    endgenerate

    logic [NUM_PINS-1:0]   w_deb;
    logic [NUM_PINS-1:0]   w_rise;
    logic [NUM_PINS-1:0]   w_fall;
    logic [NUM_PINS-1:0]   w_evt_set;
    logic [NUM_PINS-1:0]   r_status;
    logic                  r_irq;
    logic [NUM_PINS-1:0]   r_out;
    logic [NUM_PINS-1:0]   r_oe;
    logic [SOC_GPIO_W-1:0] w_soc_in;
    logic                  w_unused_bits;

    generate
        for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
            azadi_gpio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clock    (clock),
                .reset_ni (reset_ni),
                .i_pin    (pin_i[i]),
                .o_deb    (w_deb[i]),
                .o_rise   (w_rise[i]),
                .o_fall   (w_fall[i])
            );
        end
    endgenerate

    assign w_evt_set = (w_rise & bus.evt_rise_en_i) | (w_fall & bus.evt_fall_en_i);

    // Sticky status: a new event outranks a clear arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~bus.evt_clear_i) | w_evt_set;
            r_irq    <= |r_status;
        end
    end

    // Register the SoC output and enable slice towards the pads.
    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            r_out <= '0;
            r_oe  <= '0;
        end else begin
            r_out <= bus.soc_gpio_o[PIN_OFFSET +: NUM_PINS];
            r_oe  <= bus.soc_gpio_oe[PIN_OFFSET +: NUM_PINS];
        end
    end

    // Debounced pins land on their SoC slice; every other bit reads zero.
    always_comb begin
        w_soc_in                         = '0;
        w_soc_in[PIN_OFFSET +: NUM_PINS] = w_deb;
    end

    assign pin_o            = r_out ^ OUT_INVERT;
    assign pin_oe_o         = r_oe;
    assign bus.soc_gpio_i   = w_soc_in;
    assign bus.evt_status_o = r_status;
    assign bus.irq_o        = r_irq;

    // SoC GPIO bits outside the mapped slice are intentionally ignored.
    assign w_unused_bits = ^{bus.soc_gpio_o, bus.soc_gpio_oe};

endmodule : azadi_board_gpio

`default_nettype wire

// File: tb/tb_azadi_board_gpio.sv
// ============================================================================
//  Module      : tb_azadi_board_gpio
//  Description : Directed self-checking bench for azadi_board_gpio.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_azadi_board_gpio;

    localparam int         NP  = 4;
    localparam int         W   = 20;
    localparam logic [3:0] INV = 4'b0101;

    logic          clock = 1'b0;
    logic          reset_ni;
    logic [NP-1:0] pin_i;
    logic [NP-1:0] pin_o;
    logic [NP-1:0] pin_oe_o;

    int n_cmp = 0;
    int n_err = 0;

    azadi_board_gpio_if #(.NUM_PINS(NP), .SOC_GPIO_W(W)) bus ();

    azadi_board_gpio #(
        .NUM_PINS        (NP),
        .SOC_GPIO_W      (W),
        .PIN_OFFSET      (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .OUT_INVERT      (INV)
    ) u_dut (
        .clock    (clock),
        .reset_ni (reset_ni),
        .pin_i    (pin_i),
        .pin_o    (pin_o),
        .pin_oe_o (pin_oe_o),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        repeat (3) tick();
        n_cmp++; if (pin_o !== INV) begin n_err++; $display("FAIL reset_pin_o: got %b want %b", pin_o, INV); end
        n_cmp++; if (pin_oe_o !== 4'b0000) begin n_err++; $display("FAIL reset_pin_oe: got %b want 0000", pin_oe_o); end
        n_cmp++; if (bus.soc_gpio_i !== 20'h0) begin n_err++; $display("FAIL reset_soc_gpio_i: got %h want 00000", bus.soc_gpio_i); end
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq_o); end
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want 0000", bus.evt_status_o); end
        reset_ni = 1'b1;
        tick();
    endtask

    task automatic test_rise_event();
        bus.evt_rise_en_i = 4'b0001;
        pin_i[0] = 1'b1;
        repeat (5) tick();
        n_cmp++; if (bus.soc_gpio_i[16] !== 1'b0) begin n_err++; $display("FAIL rise_latency_early: got %b want 0", bus.soc_gpio_i[16]); end
        tick();
        n_cmp++; if (bus.soc_gpio_i[16] !== 1'b1) begin n_err++; $display("FAIL rise_latency_6: got %b want 1", bus.soc_gpio_i[16]); end
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL rise_status_early: got %b want 0000", bus.evt_status_o); end
        tick();
        n_cmp++; if (bus.evt_status_o !== 4'b0001) begin n_err++; $display("FAIL rise_status_set: got %b want 0001", bus.evt_status_o); end
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL rise_irq_early: got %b want 0", bus.irq_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1) begin n_err++; $display("FAIL rise_irq_set: got %b want 1", bus.irq_o); end
        n_cmp++; if (bus.evt_status_o !== 4'b0001) begin n_err++; $display("FAIL rise_status_sticky: got %b want 0001", bus.evt_status_o); end
        bus.evt_clear_i = 4'b0001;
        tick();
        bus.evt_clear_i = 4'b0000;
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL rise_clear: got %b want 0000", bus.evt_status_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL rise_irq_drop: got %b want 0", bus.irq_o); end
    endtask

    task automatic test_glitch();
        bus.evt_rise_en_i = 4'b0011;
        pin_i[1] = 1'b1;
        repeat (3) tick();
        pin_i[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++; if (bus.soc_gpio_i[17] !== 1'b0) begin n_err++; $display("FAIL glitch_deb[%0d]: got %b want 0", k, bus.soc_gpio_i[17]); end
        end
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL glitch_status: got %b want 0000", bus.evt_status_o); end
    endtask

    task automatic test_fall_clear();
        bus.evt_rise_en_i = 4'b0000;
        bus.evt_fall_en_i = 4'b0000;
        pin_i[2] = 1'b1;
        repeat (8) tick();
        n_cmp++; if (bus.soc_gpio_i[18] !== 1'b1) begin n_err++; $display("FAIL fall_prep_high: got %b want 1", bus.soc_gpio_i[18]); end
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL fall_prep_status: got %b want 0000", bus.evt_status_o); end
        bus.evt_fall_en_i = 4'b0100;
        pin_i[2] = 1'b0;
        repeat (5) tick();
        n_cmp++; if (bus.soc_gpio_i[18] !== 1'b1) begin n_err++; $display("FAIL fall_latency_early: got %b want 1", bus.soc_gpio_i[18]); end
        tick();
        n_cmp++; if (bus.soc_gpio_i[18] !== 1'b0) begin n_err++; $display("FAIL fall_latency_6: got %b want 0", bus.soc_gpio_i[18]); end
        // Clear lands on the same edge the fall event is latched.
        bus.evt_clear_i = 4'b0100;
        tick();
        bus.evt_clear_i = 4'b0000;
        n_cmp++; if (bus.evt_status_o !== 4'b0100) begin n_err++; $display("FAIL fall_set_wins: got %b want 0100", bus.evt_status_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b1) begin n_err++; $display("FAIL fall_irq_set: got %b want 1", bus.irq_o); end
        bus.evt_clear_i = 4'b0100;
        tick();
        bus.evt_clear_i = 4'b0000;
        n_cmp++; if (bus.evt_status_o !== 4'b0000) begin n_err++; $display("FAIL fall_clear: got %b want 0000", bus.evt_status_o); end
        n_cmp++; if (bus.irq_o !== 1'b1) begin n_err++; $display("FAIL fall_irq_hold: got %b want 1", bus.irq_o); end
        tick();
        n_cmp++; if (bus.irq_o !== 1'b0) begin n_err++; $display("FAIL fall_irq_drop: got %b want 0", bus.irq_o); end
    endtask

    task automatic test_outputs();
        bus.soc_gpio_o  = 20'hA3C3C;
        bus.soc_gpio_oe = 20'hF0F0F;
        #1;
        n_cmp++; if (pin_o !== INV) begin n_err++; $display("FAIL out_not_yet: got %b want %b", pin_o, INV); end
        tick();
        n_cmp++; if (pin_o !== 4'hF) begin n_err++; $display("FAIL out_pin_a: got %h want f", pin_o); end
        n_cmp++; if (pin_oe_o !== 4'hF) begin n_err++; $display("FAIL out_oe_a: got %h want f", pin_oe_o); end
        bus.soc_gpio_o  = 20'h3FFFF;
        bus.soc_gpio_oe = 20'h50000;
        tick();
        n_cmp++; if (pin_o !== 4'h6) begin n_err++; $display("FAIL out_pin_b: got %h want 6", pin_o); end
        n_cmp++; if (pin_oe_o !== 4'h5) begin n_err++; $display("FAIL out_oe_b: got %h want 5", pin_oe_o); end
        bus.soc_gpio_o  = 20'h0;
        bus.soc_gpio_oe = 20'h0;
        tick();
    endtask

    task automatic test_reset_mid_debounce();
        bus.evt_rise_en_i = 4'b1000;
        bus.evt_fall_en_i = 4'b1000;
        pin_i = 4'b1000;
        repeat (4) tick();
        reset_ni = 1'b0;
        pin_i    = 4'b0000;
        repeat (2) tick();
        n_cmp++; if (bus.soc_gpio_i !== 20'h0) begin n_err++; $display("FAIL rstmid_soc_in: got %h want 00000", bus.soc_gpio_i); end
        n_cmp++; if (pin_o !== INV) begin n_err++; $display("FAIL rstmid_pin_o: got %b want %b", pin_o, INV); end
        reset_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.soc_gpio_i !== 20'h0 || bus.evt_status_o !== 4'b0000 || bus.irq_o !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_quiet[%0d]: got in=%h st=%b irq=%b want 00000/0000/0",
                         k, bus.soc_gpio_i, bus.evt_status_o, bus.irq_o);
            end
        end
        // A fresh run after reset must take the full latency again.
        pin_i[3] = 1'b1;
        repeat (5) tick();
        n_cmp++; if (bus.soc_gpio_i[19] !== 1'b0) begin n_err++; $display("FAIL rstmid_relat_early: got %b want 0", bus.soc_gpio_i[19]); end
        tick();
        n_cmp++; if (bus.soc_gpio_i[19] !== 1'b1) begin n_err++; $display("FAIL rstmid_relat_6: got %b want 1", bus.soc_gpio_i[19]); end
        tick();
        n_cmp++; if (bus.evt_status_o !== 4'b1000) begin n_err++; $display("FAIL rstmid_status: got %b want 1000", bus.evt_status_o); end
    endtask

    initial begin
        reset_ni          = 1'b0;
        pin_i             = '0;
        bus.soc_gpio_o    = '0;
        bus.soc_gpio_oe   = '0;
        bus.evt_rise_en_i = '0;
        bus.evt_fall_en_i = '0;
        bus.evt_clear_i   = '0;

        test_reset();
        test_rise_event();
        test_glitch();
        test_fall_clear();
        test_outputs();
        test_reset_mid_debounce();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_azadi_board_gpio

`default_nettype wire
